ksa_swap_fsm: RTL and testbench

Sequencer for the RC4 key-scheduling swap loop over the 256-byte `s_memory`. It runs after the memory-init FSM has written S[i]=i, and is granted the same single-port memory once that FSM is finished. Per byte index i it computes j = j + S[i] + key[i mod 3] and swaps S[i] and S[j], driving the memory's address, write-data and write-enable. On completion it holds `done` for the downstream decrypt/PRGA stage.

---
 rtl/ksa_pkg.sv | 25 ++
 rtl/ksa_swap_fsm.sv | 108 ++++++++++
 tb/tb_ksa_swap_fsm.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ksa_pkg.sv
// ksa_pkg: state encoding and memory geometry shared by the RC4 key-scheduling swap sequencer.
// Revision 1.0 - initial release.
`default_nettype none

package ksa_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_I  = 3'd1,
    GET_I = 3'd2,
    RD_J  = 3'd3,
    GET_J = 3'd4,
    WR_I  = 3'd5,
    WR_J  = 3'd6,
    DONE  = 3'd7
  } ksa_state_t;

  localparam int ADDR_W            = 8;
  localparam int DATA_W            = 8;
  localparam int MEM_DEPTH         = 256;
  localparam int DEFAULT_KEY_BYTES = 3;

endpackage

`default_nettype wire

// File: rtl/ksa_swap_fsm.sv
// ksa_swap_fsm: RC4 key-scheduling swap loop over a 256-byte single-port S memory.
// Revision 1.0 - initial release.
`default_nettype none

module ksa_swap_fsm
  import ksa_pkg::*;
#(
  parameter int KEY_BYTES = DEFAULT_KEY_BYTES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [8*KEY_BYTES-1:0]    key,
  input  logic [DATA_W-1:0]         rd_data,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      wr_en,
  output logic                      busy,
  output logic                      done
);

  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);
  localparam logic [ADDR_W-1:0] I_LAST    = ADDR_W'(MEM_DEPTH - 1);

  ksa_state_t          state;
  logic [ADDR_W-1:0]   i;
  logic [ADDR_W-1:0]   j;
  logic [KIDX_W-1:0]   kidx;
  logic [DATA_W-1:0]   si;
  logic [DATA_W-1:0]   sj;
  logic [DATA_W-1:0]   key_byte;

  // Byte 0 of the key sits in the most significant position.
  assign key_byte = key[8*(KEY_BYTES-1-int'(kidx)) +: 8];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      kidx  <= '0;
      si    <= '0;
      sj    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            i     <= '0;
            j     <= '0;
            kidx  <= '0;
            state <= RD_I;
          end
        end
        RD_I:  state <= GET_I;
        GET_I: begin
          si    <= rd_data;
          j     <= j + rd_data + key_byte;
          state <= RD_J;
        end
        RD_J:  state <= GET_J;
        GET_J: begin
          sj    <= rd_data;
          state <= WR_I;
        end
        WR_I:  state <= WR_J;
        WR_J: begin
          if (i == I_LAST) begin
            state <= DONE;
          end else begin
            i     <= i + ADDR_W'(1);
            kidx  <= (kidx == KIDX_LAST) ? '0 : kidx + KIDX_W'(1);
            state <= RD_I;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Port is driven to zero whenever the sequencer does not own the memory.
  always_comb begin
    mem_addr = '0;
    wr_data  = '0;
    wr_en    = 1'b0;
    case (state)
      RD_I:    mem_addr = i;
      RD_J:    mem_addr = j;
      WR_I: begin
        mem_addr = i;
        wr_data  = sj;
        wr_en    = 1'b1;
      end
      WR_J: begin
        mem_addr = j;
        wr_data  = si;
        wr_en    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_ksa_swap_fsm.sv
// tb_ksa_swap_fsm: directed self-checking bench with a 1-cycle-latency memory model and a golden RC4 KSA.
// Revision 1.0 - initial release.
`default_nettype none

module tb_ksa_swap_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] key;
  logic [7:0]  rd_data;
  logic [7:0]  mem_addr;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        busy;
  logic        done;

  logic [7:0]  mem  [256];
  logic [7:0]  gold [256];
  logic        init_req;

  int n_pass;
  int n_checks;

  ksa_swap_fsm #(.KEY_BYTES(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .key      (key),
    .rd_data  (rd_data),
    .mem_addr (mem_addr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Single-port memory, registered read data, init request rewrites S[i]=i.
  always @(posedge clk) begin
    if (init_req) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (wr_en) begin
      mem[mem_addr] <= wr_data;
    end
    rd_data <= mem[mem_addr];
  end

  task automatic compute_gold(input logic [23:0] k);
    logic [7:0] jj;
    logic [7:0] t;
    logic [7:0] kb;
    jj = 8'h00;
    for (int n = 0; n < 256; n++) gold[n] = 8'(n);
    for (int n = 0; n < 256; n++) begin
      kb = 8'(k >> (8 * (2 - (n % 3))));
      jj = jj + gold[n] + kb;
      t = gold[n];
      gold[n] = gold[jj];
      gold[jj] = t;
    end
  endtask

  task automatic count_gold_diffs(output int bad, output int first);
    bad = 0;
    first = -1;
    for (int n = 0; n < 256; n++) begin
      if (mem[n] !== gold[n]) begin
        bad++;
        if (first < 0) first = n;
      end
    end
  endtask

  task automatic do_init();
    @(negedge clk);
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
  endtask

  // Pulses start and returns the number of negedges until done is seen.
  task automatic run_to_done(input bit toggle_busy, output int cyc);
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (toggle_busy && cyc >= 10 && cyc <= 20) start = cyc[0];
      if (cyc == 21) start = 1'b0;
    end while (!done && cyc < 3000);
  endtask

  task automatic idle_scan(input int ncyc, input logic exp_done, output int bad);
    bad = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (wr_en !== 1'b0 || mem_addr !== 8'h00 || wr_data !== 8'h00 ||
          busy !== 1'b0 || done !== exp_done) bad++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    key = 24'h0;
    init_req = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({mem_addr, wr_data, wr_en, busy, done} !== 19'h0)
      $display("FAIL reset_outputs: got addr=%h data=%h we=%b busy=%b done=%b, want all 0",
               mem_addr, wr_data, wr_en, busy, done);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_first_iters();
    int bad;
    key = 24'h000249;
    do_init();
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 7) begin
        bad = 0;
        for (int n = 0; n < 8; n++) if (mem[n] !== 8'(n)) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL iter0_unchanged: %0d bytes changed, want 0", bad);
        else n_pass++;
      end
      if (c == 9) begin
        n_checks++;
        if (mem_addr !== 8'h03) $display("FAIL iter1_j: got %h want 03", mem_addr);
        else n_pass++;
      end
      if (c == 13) begin
        n_checks++;
        if (mem[1] !== 8'h03 || mem[3] !== 8'h01)
          $display("FAIL iter1_swap: got S1=%h S3=%h want 03 01", mem[1], mem[3]);
        else n_pass++;
      end
      if (c == 19) begin
        n_checks++;
        if (mem[2] !== 8'h4E || mem[8'h4E] !== 8'h02)
          $display("FAIL iter2_swap: got S2=%h S4E=%h want 4e 02", mem[2], mem[8'h4E]);
        else n_pass++;
      end
      if (done) break;
    end
  endtask

  task automatic test_full_run();
    int cyc, bad, first;
    logic [255:0] seen;
    key = 24'h000249;
    compute_gold(key);
    do_init();
    run_to_done(1'b0, cyc);
    n_checks++;
    if (cyc != 1537) $display("FAIL full_latency: done after %0d negedges, want 1537", cyc);
    else n_pass++;
    count_gold_diffs(bad, first);
    n_checks++;
    if (bad != 0) $display("FAIL full_gold: %0d bytes differ, first at %0d, want 0", bad, first);
    else n_pass++;
    seen = '0;
    for (int n = 0; n < 256; n++) seen[mem[n]] = 1'b1;
    n_checks++;
    if (seen !== {256{1'b1}}) $display("FAIL full_perm: S is not a permutation, got %h", seen);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int bad, first;
    key = 24'hFFFFFF;
    compute_gold(key);
    do_init();
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 3 || c == 9 || c == 15) begin
        n_checks++;
        if (mem_addr !== ((c == 15) ? 8'h00 : 8'hFF))
          $display("FAIL wrap_j_at_%0d: got %h want %h", c, mem_addr, (c == 15) ? 8'h00 : 8'hFF);
        else n_pass++;
      end
      if (done) break;
    end
    count_gold_diffs(bad, first);
    n_checks++;
    if (bad != 0) $display("FAIL wrap_gold: %0d bytes differ, first at %0d, want 0", bad, first);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc, bad, first;
    key = 24'h000249;
    compute_gold(key);
    do_init();
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 701; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    n_checks++;
    if (wr_en !== 1'b1 || mem_addr !== 8'h74)
      $display("FAIL mid_wr_i: got we=%b addr=%h want 1 74", wr_en, mem_addr);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({mem_addr, wr_data, wr_en, busy, done} !== 19'h0)
      $display("FAIL mid_reset_outputs: got addr=%h data=%h we=%b busy=%b done=%b, want all 0",
               mem_addr, wr_data, wr_en, busy, done);
    else n_pass++;
    reset = 1'b0;
    idle_scan(5, 1'b0, bad);
    n_checks++;
    if (bad != 0) $display("FAIL idle_port: %0d bad cycles, want 0", bad);
    else n_pass++;
    do_init();
    run_to_done(1'b0, cyc);
    count_gold_diffs(bad, first);
    n_checks++;
    if (cyc != 1537 || bad != 0)
      $display("FAIL rerun_after_reset: latency %0d diffs %0d, want 1537 0", cyc, bad);
    else n_pass++;
  endtask

  task automatic test_start_busy();
    int cyc, bad, first;
    key = 24'h000249;
    compute_gold(key);
    do_init();
    run_to_done(1'b1, cyc);
    count_gold_diffs(bad, first);
    n_checks++;
    if (cyc != 1537 || bad != 0)
      $display("FAIL start_while_busy: latency %0d diffs %0d, want 1537 0", cyc, bad);
    else n_pass++;
  endtask

  task automatic test_restart();
    int cyc, bad, first;
    idle_scan(6, 1'b1, bad);
    n_checks++;
    if (bad != 0) $display("FAIL done_port: %0d bad cycles, want 0", bad);
    else n_pass++;
    key = 24'h1A2B3C;
    compute_gold(key);
    do_init();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1)
      $display("FAIL restart_from_done: got done=%b busy=%b want 0 1", done, busy);
    else n_pass++;
    cyc = 1;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    count_gold_diffs(bad, first);
    n_checks++;
    if (cyc != 1537 || bad != 0)
      $display("FAIL restart_result: latency %0d diffs %0d, want 1537 0", cyc, bad);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_checks = 0;
    test_reset();
    test_first_iters();
    test_full_run();
    test_wrap();
    test_reset_mid();
    test_start_busy();
    test_restart();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
